// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and valid/ready key output.
// Optional digit-history shift register on data_out enabled by KEYPAD_SHIFT_EN.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  ROW,
    input  logic [3:0]  COL,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        overrun,
    output logic [31:0] data_out
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0]    DB_LAST    = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    logic [3:0]    col_meta_r, col_sync_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    row_idx_r;
    logic [3:0]    row_r;
    logic [1:0]    acc_hits_r;
    logic          acc_multi_r;
    logic [3:0]    acc_code_r;
    state_t        state_r, state_nx;
    logic [3:0]    cand_r, cand_nx;
    logic [7:0]    cnt_r, cnt_nx;
    logic [7:0]    rel_r, rel_nx;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic          overrun_r;

    logic          tick_s, scan_done_s;
    logic          row_hit_s, row_multi_s;
    logic [1:0]    row_col_s;
    logic [1:0]    base_hits_s, hits_nx_s;
    logic          base_multi_s, multi_nx_s;
    logic [3:0]    code_nx_s;
    logic          res_key_s, res_none_s;
    logic          accept_s, load_s, drop_s, consume_s;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign scan_done_s = tick_s && (row_idx_r == 2'd3);

    // Column synchronizer, prescaler and row rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
            presc_r    <= '0;
            row_idx_r  <= 2'd0;
            row_r      <= 4'b1110;
        end else begin
            col_meta_r <= COL;
            col_sync_r <= col_meta_r;
            if (tick_s) begin
                presc_r   <= '0;
                row_idx_r <= row_idx_r + 2'd1;
                row_r     <= {row_r[2:0], row_r[3]};
            end else begin
                presc_r   <= presc_r + PW'(1);
            end
        end
    end

    // Classify the sampled column pattern for the active row.
    always_comb begin
        row_hit_s   = 1'b0;
        row_multi_s = 1'b0;
        row_col_s   = 2'd0;
        case (col_sync_r)
            4'b1110: begin row_hit_s = 1'b1; row_col_s = 2'd0; end
            4'b1101: begin row_hit_s = 1'b1; row_col_s = 2'd1; end
            4'b1011: begin row_hit_s = 1'b1; row_col_s = 2'd2; end
            4'b0111: begin row_hit_s = 1'b1; row_col_s = 2'd3; end
            4'b1111: row_hit_s = 1'b0;
            default: row_multi_s = 1'b1;
        endcase
    end

    // Fold this row into the running scan; row 0 starts a fresh scan.
    always_comb begin
        base_hits_s  = acc_hits_r;
        base_multi_s = acc_multi_r;
        if (row_idx_r == 2'd0) begin
            base_hits_s  = 2'd0;
            base_multi_s = 1'b0;
        end else begin
            base_hits_s  = acc_hits_r;
            base_multi_s = acc_multi_r;
        end
        if (row_hit_s && (base_hits_s != 2'd2)) begin
            hits_nx_s = base_hits_s + 2'd1;
        end else begin
            hits_nx_s = base_hits_s;
        end
        multi_nx_s = base_multi_s | row_multi_s;
        code_nx_s  = row_hit_s ? {row_idx_r, row_col_s} : acc_code_r;
        res_key_s  = !multi_nx_s && (hits_nx_s == 2'd1);
        res_none_s = !multi_nx_s && (hits_nx_s == 2'd0);
    end

    // Scan accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits_r  <= 2'd0;
            acc_multi_r <= 1'b0;
            acc_code_r  <= 4'd0;
        end else if (tick_s) begin
            acc_hits_r  <= hits_nx_s;
            acc_multi_r <= multi_nx_s;
            acc_code_r  <= code_nx_s;
        end else begin
            acc_hits_r  <= acc_hits_r;
            acc_multi_r <= acc_multi_r;
            acc_code_r  <= acc_code_r;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= 8'd0;
            rel_r   <= 8'd0;
        end else begin
            state_r <= state_nx;
            cand_r  <= cand_nx;
            cnt_r   <= cnt_nx;
            rel_r   <= rel_nx;
        end
    end

    // Debounce next-state logic, evaluated once per completed scan.
    always_comb begin
        state_nx = state_r;
        cand_nx  = cand_r;
        cnt_nx   = cnt_r;
        rel_nx   = rel_r;
        accept_s = 1'b0;
        if (scan_done_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (res_key_s) begin
                        cand_nx = code_nx_s;
                        cnt_nx  = 8'd1;
                        if (DB_LAST == 8'd1) begin
                            accept_s = 1'b1;
                            rel_nx   = 8'd0;
                            state_nx = ST_HELD;
                        end else begin
                            state_nx = ST_PRESS;
                        end
                    end else begin
                        cnt_nx = 8'd0;
                    end
                end
                ST_PRESS: begin
                    if (res_key_s && (code_nx_s == cand_r)) begin
                        cnt_nx = cnt_r + 8'd1;
                        if ((cnt_r + 8'd1) == DB_LAST) begin
                            accept_s = 1'b1;
                            rel_nx   = 8'd0;
                            state_nx = ST_HELD;
                        end else begin
                            state_nx = ST_PRESS;
                        end
                    end else begin
                        cnt_nx   = 8'd0;
                        state_nx = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (res_none_s) begin
                        if ((rel_r + 8'd1) == DB_LAST) begin
                            rel_nx   = 8'd0;
                            cnt_nx   = 8'd0;
                            state_nx = ST_IDLE;
                        end else begin
                            rel_nx = rel_r + 8'd1;
                        end
                    end else begin
                        rel_nx = 8'd0;
                    end
                end
                default: begin
                    cnt_nx   = 8'd0;
                    rel_nx   = 8'd0;
                    state_nx = ST_IDLE;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    assign load_s    = accept_s && (!key_valid_r || key_ready);
    assign drop_s    = accept_s && !load_s;
    assign consume_s = !accept_s && key_valid_r && key_ready;

    // Output handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r <= drop_s;
            if (load_s) begin
                key_code_r  <= cand_nx;
                key_valid_r <= 1'b1;
            end else if (consume_s) begin
                key_valid_r <= 1'b0;
            end else begin
                key_valid_r <= key_valid_r;
            end
        end
    end

    assign ROW       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign overrun   = overrun_r;

`ifdef KEYPAD_SHIFT_EN
    logic [31:0] hist_r;

    // Digit history: shift in each delivered key, oldest nibble drops off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 32'h0;
        end else if (load_s) begin
            hist_r <= {hist_r[27:0], cand_nx};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign data_out = hist_r;
`else
    assign data_out = 32'h0;
`endif

endmodule
